// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, decoder offer port and branch controls.
// The master modport is the fetch unit; the slave modport is memory plus decoder.
interface inst_fetch_unit_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OFF_W = 6
);
  localparam int unsigned INSTR_W = 17;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_req;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;
  logic               br_valid;
  logic [1:0]         BS;
  logic               PS;
  logic               Z;
  logic               N;
  logic [OFF_W-1:0]   br_offset;
  logic [PC_W-1:0]    jr_target;
  logic [PC_W-1:0]    pc_out;
  logic               fetch_err;

  modport master (
    output imem_addr, imem_req, instr_out, instr_valid, pc_out, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, br_valid, BS, PS, Z, N, br_offset, jr_target
  );

  modport slave (
    input  imem_addr, imem_req, instr_out, instr_valid, pc_out, fetch_err,
    output imem_ack, imem_rdata, instr_ready, br_valid, BS, PS, Z, N, br_offset, jr_target
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Non-pipelined instruction fetch: fetch one word, offer it to the decoder,
// then resolve the next PC from the decoder's branch controls and Z/N flags.
module inst_fetch_unit #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned OFF_W    = 6,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_fetch_unit_if.master    bus
);
  localparam int unsigned INSTR_W = 17;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_OFFER   = 3'd2;
  localparam logic [2:0] S_RESOLVE = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  logic [2:0]         r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [CNT_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
  logic               r_imem_req, r_instr_valid, r_fetch_err;
  logic [PC_W-1:0]    w_pc_inc, w_off_ext, w_br_target;
  logic               w_cond, w_tmo_hit;

  // Timeout fires on the FETCH cycle that would bring the miss count up to TIMEOUT.
  assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Branch target; all arithmetic wraps modulo 2^PC_W.
  always_comb begin
    w_pc_inc  = r_pc + PC_W'(1);
    w_off_ext = PC_W'($signed(bus.br_offset));
    w_cond    = bus.PS ? bus.N : bus.Z;
    case (bus.BS)
      2'b00:   w_br_target = w_pc_inc;
      2'b01:   w_br_target = w_cond ? (w_pc_inc + w_off_ext) : w_pc_inc;
      2'b10:   w_br_target = bus.jr_target;
      default: w_br_target = w_pc_inc + w_off_ext;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_tmo_cnt_nxt = r_tmo_cnt;
    case (r_state)
      S_IDLE: begin
        w_state_nxt   = S_FETCH;
        w_tmo_cnt_nxt = '0;
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          w_instr_nxt = bus.imem_rdata;
          w_state_nxt = S_OFFER;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + CNT_W'(1);
        end
      end
      S_OFFER: begin
        if (bus.instr_ready) w_state_nxt = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (bus.br_valid) begin
          w_pc_nxt      = w_br_target;
          w_state_nxt   = S_FETCH;
          w_tmo_cnt_nxt = '0;
        end
      end
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_W'(RESET_PC);
      r_instr       <= '0;
      r_tmo_cnt     <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_tmo_cnt     <= w_tmo_cnt_nxt;
      r_imem_req    <= (w_state_nxt == S_FETCH);
      r_instr_valid <= (w_state_nxt == S_OFFER);
      r_fetch_err   <= (w_state_nxt == S_ERROR);
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.imem_req    = r_imem_req;
  assign bus.instr_out   = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.pc_out      = r_pc;
  assign bus.fetch_err   = r_fetch_err;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: randomized handshakes and branch
// controls checked against a PC/memory reference model.
module tb_inst_fetch_unit;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned OFF_W   = 6;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;
  int   model_pc;
  logic [16:0] mem [256];

  inst_fetch_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

  inst_fetch_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .RESET_PC(0), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference next-PC: plain integer arithmetic on the branch rules, wrapped to 8 bits.
  function automatic int ref_next(int pc, int bs, bit ps, bit z, bit n, int off, int jr);
    int soff;
    bit taken;
    soff  = (off >= 32) ? off - 64 : off;
    taken = ps ? n : z;
    case (bs)
      0:       return (pc + 1) & 255;
      1:       return taken ? ((pc + 1 + soff) & 255) : ((pc + 1) & 255);
      2:       return jr & 255;
      default: return (pc + 1 + soff) & 255;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus.br_valid = 1'b0; bus.BS = 2'b00; bus.PS = 1'b0; bus.Z = 1'b0; bus.N = 1'b0;
    bus.br_offset = '0; bus.jr_target = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_pc = 0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.imem_req === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Drives one instruction through fetch, offer and resolve; reports what was seen.
  task automatic run_instr(input int ack_dly, input int rdy_dly, input int br_dly, input bit noise,
                           input logic [1:0] bs, input logic ps, input logic z, input logic n,
                           input logic [5:0] off, input logic [7:0] jr,
                           output logic [7:0] addr, output logic [16:0] word,
                           output bit hold_ok, output bit got_req);
    hold_ok = 1'b1; addr = '0; word = '0;
    wait_req(got_req);
    if (!got_req) return;
    addr = bus.imem_addr;
    for (int i = 0; i < ack_dly; i++) begin
      bus.imem_ack = 1'b0;
      if (noise) begin
        bus.instr_ready = 1'($urandom_range(0, 1));
        bus.br_valid    = 1'($urandom_range(0, 1));
        bus.BS          = 2'($urandom);
      end
      @(negedge clk);
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr || bus.instr_valid !== 1'b0) hold_ok = 1'b0;
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem[addr]; bus.instr_ready = 1'b0; bus.br_valid = 1'b0;
    @(negedge clk);
    bus.imem_ack = 1'b0; bus.imem_rdata = 17'($urandom);
    word = bus.instr_out;
    if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) hold_ok = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      if (noise) begin
        bus.imem_ack   = 1'($urandom_range(0, 1));
        bus.imem_rdata = 17'($urandom);
        bus.br_valid   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (bus.instr_valid !== 1'b1 || bus.instr_out !== word || bus.imem_req !== 1'b0) hold_ok = 1'b0;
    end
    bus.instr_ready = 1'b1; bus.imem_ack = 1'b0; bus.br_valid = 1'b0;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    if (bus.instr_valid !== 1'b0) hold_ok = 1'b0;
    for (int i = 0; i < br_dly; i++) begin
      if (noise) begin
        bus.imem_ack    = 1'($urandom_range(0, 1));
        bus.instr_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) hold_ok = 1'b0;
    end
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    bus.br_valid = 1'b1; bus.BS = bs; bus.PS = ps; bus.Z = z; bus.N = n;
    bus.br_offset = off; bus.jr_target = jr;
    @(negedge clk);
    bus.br_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit got;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.imem_req, bus.instr_valid, bus.fetch_err} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: req/valid/err=%b expected 000", {bus.imem_req, bus.instr_valid, bus.fetch_err});
    end
    vectors++;
    if (bus.pc_out !== 8'h00 || bus.instr_out !== 17'h0) begin
      errors++; $display("FAIL reset_data: pc=%h instr=%h expected 00/00000", bus.pc_out, bus.instr_out);
    end
    rst = 1'b0;
    model_pc = 0;
    wait_req(got);
    vectors++;
    if (!got || bus.imem_addr !== 8'h00) begin
      errors++; $display("FAIL reset_first_fetch: got_req=%0d addr=%h expected 1/00", got, bus.imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [7:0] a; logic [16:0] w; bit h, g;
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 8'h0, a, w, h, g);
      vectors++;
      if (!g || a !== 8'(i) || w !== mem[i] || !h) begin
        errors++; $display("FAIL seq_%0d: addr=%h word=%h hold=%0d expected addr=%h word=%h", i, a, w, h, 8'(i), mem[i]);
      end
      model_pc = ref_next(model_pc, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_branch_cond();
    logic [7:0] a; logic [16:0] w; bit h, g;
    run_instr(0, 0, 0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 6'h0, 8'h05, a, w, h, g);
    run_instr(1, 0, 1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 6'h3E, 8'h0, a, w, h, g);
    vectors++;
    if (a !== 8'h05) begin errors++; $display("FAIL cond_setup: addr=%h expected 05", a); end
    wait_req(g);
    vectors++;
    if (!g || bus.imem_addr !== 8'h04) begin errors++; $display("FAIL cond_taken: addr=%h expected 04", bus.imem_addr); end
    run_instr(0, 0, 0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 6'h0, 8'h05, a, w, h, g);
    run_instr(0, 1, 0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 6'h3E, 8'h0, a, w, h, g);
    wait_req(g);
    vectors++;
    if (!g || bus.imem_addr !== 8'h06) begin errors++; $display("FAIL cond_not_taken: addr=%h expected 06", bus.imem_addr); end
    model_pc = 6;
  endtask

  task automatic test_wrap();
    logic [7:0] a; logic [16:0] w; bit h, g;
    run_instr(0, 0, 0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 6'h0, 8'hFF, a, w, h, g);
    run_instr(0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 8'h0, a, w, h, g);
    vectors++;
    if (a !== 8'hFF || w !== mem[255]) begin errors++; $display("FAIL wrap_ff: addr=%h word=%h expected ff/%h", a, w, mem[255]); end
    run_instr(0, 0, 0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 6'h0, 8'h40, a, w, h, g);
    vectors++;
    if (a !== 8'h00) begin errors++; $display("FAIL wrap_00: addr=%h expected 00", a); end
    vectors++;
    if (bus.imem_addr !== 8'h40 || bus.pc_out !== 8'h40) begin
      errors++; $display("FAIL jump_reg: addr=%h pc=%h expected 40", bus.imem_addr, bus.pc_out);
    end
    model_pc = 'h40;
  endtask

  task automatic test_stall();
    logic [7:0] a; logic [16:0] w; bit h, g;
    run_instr(2, 5, 3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 8'h0, a, w, h, g);
    vectors++;
    if (!h || a !== 8'(model_pc) || w !== mem[a]) begin
      errors++; $display("FAIL ready_stall: hold=%0d addr=%h word=%h expected 1/%h/%h", h, a, w, 8'(model_pc), mem[model_pc]);
    end
    model_pc = ref_next(model_pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] a; logic [16:0] w; bit h, g;
    logic [1:0] bs; logic ps, z, n; logic [5:0] off; logic [7:0] jr;
    for (int i = 0; i < 40; i++) begin
      bs = 2'($urandom); ps = 1'($urandom); z = 1'($urandom); n = 1'($urandom);
      off = 6'($urandom); jr = 8'($urandom);
      run_instr($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4), 1'b1,
                bs, ps, z, n, off, jr, a, w, h, g);
      vectors++;
      if (!g || !h || a !== 8'(model_pc) || w !== mem[model_pc]) begin
        errors++; $display("FAIL rand_%0d: req=%0d hold=%0d addr=%h word=%h expected addr=%h word=%h",
                           i, g, h, a, w, 8'(model_pc), mem[model_pc]);
      end
      model_pc = ref_next(model_pc, int'(bs), ps, z, n, int'(off), int'(jr));
      vectors++;
      if (bus.pc_out !== 8'(model_pc)) begin
        errors++; $display("FAIL rand_pc_%0d: pc=%h expected %h", i, bus.pc_out, 8'(model_pc));
      end
    end
  endtask

  task automatic test_timeout_ack16();
    logic [7:0] a; logic [16:0] w; bit h, g;
    apply_reset();
    run_instr(15, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 8'h0, a, w, h, g);
    vectors++;
    if (!h || bus.fetch_err !== 1'b0 || w !== mem[0]) begin
      errors++; $display("FAIL ack_on_16: hold=%0d err=%b word=%h expected 1/0/%h", h, bus.fetch_err, w, mem[0]);
    end
  endtask

  task automatic test_timeout_fault();
    bit g;
    apply_reset();
    wait_req(g);
    repeat (15) @(negedge clk);
    vectors++;
    if (bus.fetch_err !== 1'b0 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL tmo_15: err=%b req=%b expected 0/1", bus.fetch_err, bus.imem_req);
    end
    @(negedge clk);
    vectors++;
    if ({bus.fetch_err, bus.imem_req, bus.instr_valid} !== 3'b100) begin
      errors++; $display("FAIL tmo_16: err/req/valid=%b expected 100", {bus.fetch_err, bus.imem_req, bus.instr_valid});
    end
    bus.imem_ack = 1'b1; bus.instr_ready = 1'b1; bus.br_valid = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ({bus.fetch_err, bus.imem_req, bus.instr_valid} !== 3'b100) begin
      errors++; $display("FAIL err_sticky: err/req/valid=%b expected 100", {bus.fetch_err, bus.imem_req, bus.instr_valid});
    end
    apply_reset();
    vectors++;
    if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%b expected 0", bus.fetch_err); end
  endtask

  task automatic test_reset_in_offer();
    logic [7:0] a; logic [16:0] w; bit h, g;
    run_instr(0, 0, 0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 6'h0, 8'h33, a, w, h, g);
    wait_req(g);
    bus.imem_ack = 1'b1; bus.imem_rdata = mem[8'h33];
    @(negedge clk);
    bus.imem_ack = 1'b0;
    vectors++;
    if (bus.instr_valid !== 1'b1 || bus.instr_out !== mem[8'h33]) begin
      errors++; $display("FAIL offer_pre_rst: valid=%b instr=%h expected 1/%h", bus.instr_valid, bus.instr_out, mem[8'h33]);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.instr_valid !== 1'b0 || bus.pc_out !== 8'h00 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_in_offer: valid=%b pc=%h req=%b expected 0/00/0", bus.instr_valid, bus.pc_out, bus.imem_req);
    end
    rst = 1'b0;
    model_pc = 0;
    run_instr(0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 8'h0, a, w, h, g);
    vectors++;
    if (!g || a !== 8'h00 || w !== mem[0]) begin
      errors++; $display("FAIL refetch_0: addr=%h word=%h expected 00/%h", a, w, mem[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] = 17'($urandom);
    test_reset();
    test_sequential();
    test_branch_cond();
    test_wrap();
    test_stall();
    test_random();
    test_timeout_ack16();
    test_timeout_fault();
    test_reset_in_offer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
